// File: rtl/alu_card_ctrl.sv
// Sequencer for an external 8-bit ALU card: runs 8- or 16-bit operations as
// one or two settled byte passes, chaining the carry between bytes for ADD/SUB.
module alu_card_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic        req_wide,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_res,
    output logic        rsp_sign,
    output logic        rsp_zero,
    output logic [7:0]  card_a,
    output logic [7:0]  card_b,
    output logic [2:0]  card_op,
    output logic        card_csel,
    output logic        card_cclear,
    input  logic [7:0]  card_res,
    input  logic        card_sign,
    input  logic        card_zero
);

    localparam logic [3:0] LP_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_LO, S_HI, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic        r_wide;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [3:0]  r_cnt;
    logic        r_zlo;
    logic [15:0] r_res;
    logic        r_sign;
    logic        r_zero;
    logic        w_accept;
    logic        w_arith;
    logic        w_settled;
    logic        w_is_reg;

    assign w_accept  = req_valid & req_ready;
    assign w_is_reg  = req_op[2] & req_op[1];
    assign w_arith   = (r_op == 3'b100) || (r_op == 3'b101);
    assign w_settled = (r_cnt == LP_LAST);

    assign rsp_res  = r_res;
    assign rsp_sign = r_sign;
    assign rsp_zero = r_zero;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        card_a      = 8'h00;
        card_b      = 8'h00;
        card_op     = 3'b000;
        card_csel   = 1'b0;
        card_cclear = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = S_CLR;
            end
            S_CLR: begin
                card_a      = r_a[7:0];
                card_b      = r_b[7:0];
                card_op     = r_op;
                card_cclear = w_arith;
                w_next      = S_LO;
            end
            S_LO: begin
                card_a  = r_a[7:0];
                card_b  = r_b[7:0];
                card_op = r_op;
                if (w_settled) w_next = r_wide ? S_HI : S_RESP;
            end
            S_HI: begin
                card_a    = r_a[15:8];
                card_b    = r_b[15:8];
                card_op   = r_op;
                card_csel = w_arith;
                if (w_settled) w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request snapshot; register ops never take the high-byte pass.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op   <= req_op;
            r_wide <= req_wide & ~w_is_reg;
            r_a    <= req_a;
            r_b    <= req_b;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_cnt  <= 4'd0;
            r_zlo  <= 1'b0;
            r_res  <= 16'h0000;
            r_sign <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                S_LO: begin
                    if (w_settled) begin
                        r_cnt  <= 4'd0;
                        r_res  <= {8'h00, card_res};
                        r_zlo  <= card_zero;
                        r_sign <= w_arith ? card_sign : card_res[7];
                        r_zero <= w_arith ? card_zero : (card_res == 8'h00);
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_HI: begin
                    if (w_settled) begin
                        r_cnt        <= 4'd0;
                        r_res[15:8]  <= card_res;
                        r_sign       <= w_arith ? card_sign : card_res[7];
                        r_zero       <= w_arith ? (r_zlo & card_zero)
                                                : ((card_res == 8'h00) && (r_res[7:0] == 8'h00));
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_cnt <= 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_card_ctrl.sv
// Directed bench for alu_card_ctrl with a behavioural ALU card per instance
// (SETTLE=1 and SETTLE=2 instances share the request data bus).
module tb_alu_card_ctrl;

    localparam int S1 = 1;
    localparam int S2 = 2;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [2:0]  req_op = 3'b000;
    logic        req_wide = 1'b0;
    logic [15:0] req_a = 16'h0000;
    logic [15:0] req_b = 16'h0000;

    logic        v1 = 1'b0, rdy1, rsp_valid1, rsp_rdy1 = 1'b0, sign1, zero1;
    logic [15:0] res1;
    logic [7:0]  ca1, cb1, cres1;
    logic [2:0]  cop1;
    logic        csel1, ccl1, csgn1, czero1;

    logic        v2 = 1'b0, rdy2, rsp_valid2, rsp_rdy2 = 1'b0, sign2, zero2;
    logic [15:0] res2;
    logic [7:0]  ca2, cb2, cres2;
    logic [2:0]  cop2;
    logic        csel2, ccl2, csgn2, czero2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_card_ctrl #(.SETTLE(S1)) u_dut1 (
        .clk(clk), .clear(clear), .req_valid(v1), .req_ready(rdy1), .req_op(req_op),
        .req_wide(req_wide), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid1),
        .rsp_ready(rsp_rdy1), .rsp_res(res1), .rsp_sign(sign1), .rsp_zero(zero1),
        .card_a(ca1), .card_b(cb1), .card_op(cop1), .card_csel(csel1), .card_cclear(ccl1),
        .card_res(cres1), .card_sign(csgn1), .card_zero(czero1)
    );

    alu_card_ctrl #(.SETTLE(S2)) u_dut2 (
        .clk(clk), .clear(clear), .req_valid(v2), .req_ready(rdy2), .req_op(req_op),
        .req_wide(req_wide), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid2),
        .rsp_ready(rsp_rdy2), .rsp_res(res2), .rsp_sign(sign2), .rsp_zero(zero2),
        .card_a(ca2), .card_b(cb2), .card_op(cop2), .card_csel(csel2), .card_cclear(ccl2),
        .card_res(cres2), .card_sign(csgn2), .card_zero(czero2)
    );

    // Card model: returns {carry/borrow out, sign, zero, result}.
    function automatic logic [10:0] card_fn(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op, input logic cin);
        logic [8:0] t;
        case (op)
            3'b000:  t = {1'b0, a & b};
            3'b001:  t = {1'b0, a | b};
            3'b010:  t = {1'b0, ~a};
            3'b011:  t = {1'b0, a ^ b};
            3'b100:  t = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            3'b101:  t = {1'b0, a} - {1'b0, b} - {8'd0, cin};
            default: t = {1'b0, a};
        endcase
        return {t[8], t[7], (t[7:0] == 8'h00), t[7:0]};
    endfunction

    logic        c1_carry = 1'b0, c2_carry = 1'b0;
    logic [10:0] c1_out, c2_out;

    always_comb c1_out = card_fn(ca1, cb1, cop1, csel1 & c1_carry);
    always_comb c2_out = card_fn(ca2, cb2, cop2, csel2 & c2_carry);
    assign cres1 = c1_out[7:0];
    assign czero1 = c1_out[8];
    assign csgn1 = c1_out[9];
    assign cres2 = c2_out[7:0];
    assign czero2 = c2_out[8];
    assign csgn2 = c2_out[9];

    always_ff @(posedge clk) begin
        if (ccl1) c1_carry <= 1'b0;
        else if (!csel1 && (cop1 == 3'b100 || cop1 == 3'b101)) c1_carry <= c1_out[10];
        if (ccl2) c2_carry <= 1'b0;
        else if (!csel2 && (cop2 == 3'b100 || cop2 == 3'b101)) c2_carry <= c2_out[10];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Issue one request to the SETTLE=2 instance and follow it to rsp_valid.
    task automatic issue2(input logic [2:0] op, input logic wide, input logic [15:0] a,
                          input logic [15:0] b, output int lat, output int ncl,
                          output logic csel_lo, output logic csel_hi);
        int n;
        req_op = op; req_wide = wide; req_a = a; req_b = b; v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0; req_op = ~op; req_wide = ~wide; req_a = ~a; req_b = ~b;
        n = 1; lat = -1; ncl = 0; csel_lo = 1'bx; csel_hi = 1'bx;
        while (n <= 40 && lat < 0) begin
            if (ccl2) ncl++;
            if (n == 2) csel_lo = csel2;
            if (n == 2 + S2) csel_hi = csel2;
            if (rsp_valid2) lat = n;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
    endtask

    task automatic finish2();
        rsp_rdy2 = 1'b1;
        @(posedge clk); #1;
        rsp_rdy2 = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (2) @(posedge clk);
        #1 clear = 1'b0;
        tests++; if ({rdy1, rdy2} !== 2'b11) begin fails++; $display("FAIL reset_ready got=%b exp=11", {rdy1, rdy2}); end
        tests++; if ({rsp_valid1, rsp_valid2} !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=00", {rsp_valid1, rsp_valid2}); end
        tests++; if ({res2, sign2, zero2} !== 18'h0) begin fails++; $display("FAIL reset_rsp got=%h/%b/%b exp=0000/0/0", res2, sign2, zero2); end
        tests++; if ({ca2, cb2, cop2, csel2, ccl2} !== 21'h0) begin fails++; $display("FAIL reset_card got=%h %h %b %b %b exp=all 0", ca2, cb2, cop2, csel2, ccl2); end
    endtask

    task automatic test_narrow_add_s1();
        int n, lat, ncl;
        req_op = 3'b100; req_wide = 1'b0; req_a = 16'h0005; req_b = 16'h0003; v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0; req_a = 16'hFFFF; req_b = 16'hFFFF;
        n = 1; lat = -1; ncl = 0;
        while (n <= 40 && lat < 0) begin
            if (ccl1) ncl++;
            if (rsp_valid1) lat = n;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        tests++; if (lat != 3) begin fails++; $display("FAIL s1_add_latency got=%0d exp=3", lat); end
        tests++; if (res1 !== 16'h0008) begin fails++; $display("FAIL s1_add_res got=%h exp=0008", res1); end
        tests++; if ({sign1, zero1} !== 2'b00) begin fails++; $display("FAIL s1_add_flags got=%b exp=00", {sign1, zero1}); end
        tests++; if (ncl != 1) begin fails++; $display("FAIL s1_add_cclear_cycles got=%0d exp=1", ncl); end
        rsp_rdy1 = 1'b1;
        @(posedge clk); #1;
        rsp_rdy1 = 1'b0;
        tests++; if ({rdy1, rsp_valid1} !== 2'b10) begin fails++; $display("FAIL s1_add_idle got=%b exp=10", {rdy1, rsp_valid1}); end
    endtask

    task automatic test_wide_add();
        int lat, ncl;
        logic cl, ch;
        issue2(3'b100, 1'b1, 16'h00FF, 16'h0001, lat, ncl, cl, ch);
        tests++; if (lat != 6) begin fails++; $display("FAIL wide_add_latency got=%0d exp=6", lat); end
        tests++; if ({cl, ch} !== 2'b01) begin fails++; $display("FAIL wide_add_csel got lo=%b hi=%b exp lo=0 hi=1", cl, ch); end
        tests++; if (ncl != 1) begin fails++; $display("FAIL wide_add_cclear_cycles got=%0d exp=1", ncl); end
        tests++; if (res2 !== 16'h0100) begin fails++; $display("FAIL wide_add_res got=%h exp=0100", res2); end
        tests++; if ({sign2, zero2} !== 2'b00) begin fails++; $display("FAIL wide_add_flags got=%b exp=00", {sign2, zero2}); end
        tests++; if (rdy2 !== 1'b0) begin fails++; $display("FAIL wide_add_ready_in_resp got=%b exp=0", rdy2); end
        finish2();
        tests++; if ({rdy2, rsp_valid2} !== 2'b10) begin fails++; $display("FAIL wide_add_idle got=%b exp=10", {rdy2, rsp_valid2}); end
        issue2(3'b100, 1'b1, 16'hFF00, 16'h0100, lat, ncl, cl, ch);
        tests++; if ({res2, sign2, zero2} !== {16'h0000, 2'b01}) begin fails++; $display("FAIL wide_add_zero got=%h/%b/%b exp=0000/0/1", res2, sign2, zero2); end
        finish2();
    endtask

    task automatic test_xor_zero();
        int lat, ncl;
        logic cl, ch;
        issue2(3'b011, 1'b0, 16'h005A, 16'h005A, lat, ncl, cl, ch);
        tests++; if (lat != 4) begin fails++; $display("FAIL xor_latency got=%0d exp=4", lat); end
        tests++; if ({res2, sign2, zero2} !== {16'h0000, 2'b01}) begin fails++; $display("FAIL xor_result got=%h/%b/%b exp=0000/0/1", res2, sign2, zero2); end
        tests++; if (ncl != 0) begin fails++; $display("FAIL xor_cclear_cycles got=%0d exp=0", ncl); end
        finish2();
    endtask

    task automatic test_logic_flags();
        int lat, ncl;
        logic cl, ch;
        issue2(3'b010, 1'b0, 16'h000F, 16'h0000, lat, ncl, cl, ch);
        tests++; if ({res2, sign2, zero2} !== {16'h00F0, 2'b10}) begin fails++; $display("FAIL not_result got=%h/%b/%b exp=00f0/1/0", res2, sign2, zero2); end
        finish2();
        issue2(3'b000, 1'b1, 16'hFF00, 16'h8F0F, lat, ncl, cl, ch);
        tests++; if (lat != 6) begin fails++; $display("FAIL wide_and_latency got=%0d exp=6", lat); end
        tests++; if ({res2, sign2, zero2} !== {16'h8F00, 2'b10}) begin fails++; $display("FAIL wide_and_result got=%h/%b/%b exp=8f00/1/0", res2, sign2, zero2); end
        tests++; if ({cl, ch} !== 2'b00) begin fails++; $display("FAIL wide_and_csel got lo=%b hi=%b exp 0/0", cl, ch); end
        finish2();
    endtask

    task automatic test_reg_narrow();
        int lat, ncl;
        logic cl, ch;
        issue2(3'b110, 1'b1, 16'h12AB, 16'h0000, lat, ncl, cl, ch);
        tests++; if (lat != 4) begin fails++; $display("FAIL reg_latency got=%0d exp=4", lat); end
        tests++; if ({res2, sign2, zero2} !== {16'h00AB, 2'b10}) begin fails++; $display("FAIL reg_result got=%h/%b/%b exp=00ab/1/0", res2, sign2, zero2); end
        finish2();
    endtask

    task automatic test_backpressure();
        int lat, ncl, bad;
        logic cl, ch;
        issue2(3'b001, 1'b0, 16'h0030, 16'h0003, lat, ncl, cl, ch);
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if ({rsp_valid2, rdy2, res2, sign2, zero2} !== {2'b10, 16'h0033, 2'b00}) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL hold_stable got=%0d unstable cycles, last %b/%b/%h exp 0", bad, rsp_valid2, rdy2, res2); end
        finish2();
        tests++; if ({rdy2, rsp_valid2} !== 2'b10) begin fails++; $display("FAIL hold_release got=%b exp=10", {rdy2, rsp_valid2}); end
    endtask

    task automatic test_clear_in_hi();
        int lat, ncl, bad;
        logic cl, ch;
        req_op = 3'b101; req_wide = 1'b1; req_a = 16'h1000; req_b = 16'h0001; v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        tests++; if ({csel2, ca2} !== {1'b1, 8'h10}) begin fails++; $display("FAIL clr_hi_reached got csel=%b a=%h exp 1/10", csel2, ca2); end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        tests++; if ({rdy2, rsp_valid2} !== 2'b10) begin fails++; $display("FAIL clr_idle got=%b exp=10", {rdy2, rsp_valid2}); end
        tests++; if ({res2, sign2, zero2} !== 18'h0) begin fails++; $display("FAIL clr_rsp got=%h/%b/%b exp=0000/0/0", res2, sign2, zero2); end
        tests++; if ({ca2, cb2, cop2, csel2, ccl2} !== 21'h0) begin fails++; $display("FAIL clr_card got=%h %h %b %b %b exp=all 0", ca2, cb2, cop2, csel2, ccl2); end
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid2 !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL clr_no_resp got=%0d valid cycles exp=0", bad); end
        issue2(3'b101, 1'b1, 16'h1000, 16'h0001, lat, ncl, cl, ch);
        tests++; if (lat != 6) begin fails++; $display("FAIL sub_after_clr_latency got=%0d exp=6", lat); end
        tests++; if ({res2, sign2, zero2} !== {16'h0FFF, 2'b00}) begin fails++; $display("FAIL sub_after_clr_result got=%h/%b/%b exp=0fff/0/0", res2, sign2, zero2); end
        finish2();
    endtask

    initial begin
        test_reset();
        test_narrow_add_s1();
        test_wide_add();
        test_xor_zero();
        test_logic_flags();
        test_reg_narrow();
        test_backpressure();
        test_clear_in_hi();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
